pgr_uart2apb_burst: RTL and testbench

PGR_UART2APB_BURST -- requirements
Module: pgr_uart2apb_burst

---
 rtl/pgr_uart2apb_pkg.sv | 26 ++
 rtl/pgr_u2a_apb_xfer.sv | 76 +++++++
 rtl/pgr_uart2apb_burst.sv | 209 ++++++++++++++++++++
 tb/tb_pgr_uart2apb_burst.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pgr_uart2apb_pkg.sv
// Shared types and constants for the UART-to-APB burst bridge.
package pgr_uart2apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_SETUP,
        ST_ACCESS,
        ST_RDATA_TX,
        ST_DRAIN,
        ST_STATUS
    } state_t;

    localparam logic [7:0] STS_OK      = 8'h00;
    localparam logic [7:0] STS_SLVERR  = 8'h01;
    localparam logic [7:0] STS_TIMEOUT = 8'h02;
    localparam logic [7:0] STS_BADCMD  = 8'h03;

    localparam int CMD_WE_BIT  = 7;
    localparam int CMD_RSV_LSB = 4;
    localparam int CMD_RSV_W   = 3;
    localparam int CMD_LEN_LSB = 0;
    localparam int CMD_LEN_W   = 4;

endpackage

// File: rtl/pgr_u2a_apb_xfer.sv
// APB phase driver: decodes select, counts ACCESS cycles for timeout and
// captures read data into a byte-shift register for the serialiser.
module pgr_u2a_apb_xfer
    import pgr_uart2apb_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int NSEL    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_setup,
    input  logic              i_access,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DW-1:0]     i_wdata,
    input  logic              i_shift,
    input  logic              i_p_ready,
    input  logic [DW-1:0]     i_p_rdata,
    input  logic              i_p_slverr,
    output logic [NSEL-1:0]   o_p_sel,
    output logic [AW-1:0]     o_p_addr,
    output logic [DW-1:0]     o_p_wdata,
    output logic [DW/8-1:0]   o_p_strb,
    output logic              o_p_enable,
    output logic              o_p_we,
    output logic              o_done,
    output logic [7:0]        o_status,
    output logic [7:0]        o_rdata_byte
);
    localparam int SW = (NSEL > 1) ? $clog2(NSEL) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] acc_cnt_q;
    logic [DW-1:0] rdata_q;
    logic [SW-1:0] sel_idx;
    logic          active;
    logic          timeout_hit;

    assign active      = i_setup | i_access;
    assign sel_idx     = (NSEL > 1) ? i_addr[AW-1 -: SW] : '0;
    assign o_p_sel     = active ? (NSEL'(1) << sel_idx) : '0;
    assign o_p_addr    = active ? i_addr : '0;
    assign o_p_wdata   = active ? i_wdata : '0;
    assign o_p_strb    = active ? '1 : '0;
    assign o_p_we      = active & i_we;
    assign o_p_enable  = i_access;

    assign timeout_hit = i_access & ~i_p_ready & (acc_cnt_q == CW'(TIMEOUT - 1));
    assign o_done      = i_access & (i_p_ready | timeout_hit);
    assign o_status    = i_p_ready ? (i_p_slverr ? STS_SLVERR : STS_OK) : STS_TIMEOUT;
    assign o_rdata_byte = rdata_q[DW-1 -: 8];

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_access) begin
            acc_cnt_q <= '0;
        end else begin
            acc_cnt_q <= acc_cnt_q + 1'b1;
        end
    end

    // A failed word is replaced by zeros so the read response keeps its length.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rdata_q <= '0;
        end else if (i_access && i_p_ready) begin
            rdata_q <= i_p_slverr ? '0 : i_p_rdata;
        end else if (timeout_hit) begin
            rdata_q <= '0;
        end else if (i_shift) begin
            rdata_q <= rdata_q << 8;
        end
    end

endmodule

// File: rtl/pgr_uart2apb_burst.sv
// UART byte-stream to APB bridge: parses command frames, runs burst transfers
// through pgr_u2a_apb_xfer and serialises read data followed by a status byte.
module pgr_uart2apb_burst
    import pgr_uart2apb_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int NSEL    = 4,
    parameter int TIMEOUT = 255,
    parameter int RX_GAP  = 50000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_vld,
    output logic              o_rx_rdy,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_vld,
    input  logic              i_tx_rdy,
    output logic [NSEL-1:0]   o_p_sel,
    output logic [AW-1:0]     o_p_addr,
    output logic [DW-1:0]     o_p_wdata,
    output logic [DW/8-1:0]   o_p_strb,
    output logic              o_p_enable,
    output logic              o_p_we,
    input  logic              i_p_ready,
    input  logic [DW-1:0]     i_p_rdata,
    input  logic              i_p_slverr,
    output logic              o_busy,
    output logic              o_frame_abort,
    output state_t            o_dbg_state
);
    localparam int NB = DW / 8;
    localparam int NA = AW / 8;
    localparam int GW = $clog2(RX_GAP + 1);

    state_t                 state_q, state_d;
    logic                   we_q, we_d;
    logic [CMD_LEN_W-1:0]   len_q, len_d;
    logic [CMD_LEN_W-1:0]   widx_q, widx_d;
    logic [2:0]             bcnt_q, bcnt_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [DW-1:0]          wdata_q, wdata_d;
    logic [7:0]             status_q, status_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic                   abort_q, abort_d;
    logic                   rx_acc, tx_acc, last_word, in_rx_state, shift;
    logic                   xfer_done;
    logic [7:0]             xfer_sts, rdata_byte;

    assign in_rx_state   = (state_q inside {ST_ADDR, ST_WDATA, ST_DRAIN});
    assign o_rx_rdy      = ~i_rst & (in_rx_state | (state_q == ST_IDLE));
    assign o_tx_vld      = ~i_rst & (state_q inside {ST_RDATA_TX, ST_STATUS});
    assign o_tx_data     = !o_tx_vld ? 8'h00 : ((state_q == ST_STATUS) ? status_q : rdata_byte);
    assign o_busy        = ~i_rst & (state_q != ST_IDLE);
    assign o_frame_abort = ~i_rst & abort_q;
    assign o_dbg_state   = i_rst ? ST_IDLE : state_q;
    assign rx_acc        = o_rx_rdy & i_rx_vld;
    assign tx_acc        = o_tx_vld & i_tx_rdy;
    assign last_word     = (widx_q == len_q);

    pgr_u2a_apb_xfer #(.AW(AW), .DW(DW), .NSEL(NSEL), .TIMEOUT(TIMEOUT)) u_xfer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_setup      (~i_rst & (state_q == ST_SETUP)),
        .i_access     (~i_rst & (state_q == ST_ACCESS)),
        .i_we         (we_q),
        .i_addr       (addr_q),
        .i_wdata      (wdata_q),
        .i_shift      (shift),
        .i_p_ready    (i_p_ready),
        .i_p_rdata    (i_p_rdata),
        .i_p_slverr   (i_p_slverr),
        .o_p_sel      (o_p_sel),
        .o_p_addr     (o_p_addr),
        .o_p_wdata    (o_p_wdata),
        .o_p_strb     (o_p_strb),
        .o_p_enable   (o_p_enable),
        .o_p_we       (o_p_we),
        .o_done       (xfer_done),
        .o_status     (xfer_sts),
        .o_rdata_byte (rdata_byte)
    );

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        len_d    = len_q;
        widx_d   = widx_q;
        bcnt_d   = bcnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        status_d = status_q;
        gap_d    = gap_q;
        abort_d  = 1'b0;
        shift    = 1'b0;
        case (state_q)
            ST_IDLE: if (rx_acc) begin
                we_d     = i_rx_data[CMD_WE_BIT];
                len_d    = i_rx_data[CMD_LEN_LSB +: CMD_LEN_W];
                widx_d   = '0;
                bcnt_d   = '0;
                addr_d   = '0;
                status_d = STS_OK;
                if (i_rx_data[CMD_RSV_LSB +: CMD_RSV_W] != '0) begin
                    status_d = STS_BADCMD;
                    state_d  = ST_STATUS;
                end else begin
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR: if (rx_acc) begin
                addr_d = (addr_q << 8) | AW'(i_rx_data);
                bcnt_d = bcnt_q + 1'b1;
                if (bcnt_q == 3'(NA - 1)) begin
                    bcnt_d  = '0;
                    state_d = we_q ? ST_WDATA : ST_SETUP;
                end
            end
            ST_WDATA: if (rx_acc) begin
                wdata_d = (wdata_q << 8) | DW'(i_rx_data);
                bcnt_d  = bcnt_q + 1'b1;
                if (bcnt_q == 3'(NB - 1)) begin
                    bcnt_d  = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: if (xfer_done) begin
                addr_d   = addr_q + AW'(NB);
                status_d = xfer_sts;
                if (!we_q) begin
                    state_d = ST_RDATA_TX;
                end else if (last_word) begin
                    state_d = ST_STATUS;
                end else begin
                    widx_d  = widx_q + 1'b1;
                    state_d = (xfer_sts == STS_OK) ? ST_WDATA : ST_DRAIN;
                end
            end
            // After an error the capture register is zero, so the remaining words go out as 0x00.
            ST_RDATA_TX: if (tx_acc) begin
                shift  = 1'b1;
                bcnt_d = bcnt_q + 1'b1;
                if (bcnt_q == 3'(NB - 1)) begin
                    bcnt_d = '0;
                    if (last_word) begin
                        state_d = ST_STATUS;
                    end else begin
                        widx_d  = widx_q + 1'b1;
                        state_d = (status_q == STS_OK) ? ST_SETUP : ST_RDATA_TX;
                    end
                end
            end
            ST_DRAIN: if (rx_acc) begin
                bcnt_d = bcnt_q + 1'b1;
                if (bcnt_q == 3'(NB - 1)) begin
                    bcnt_d = '0;
                    if (last_word) begin
                        state_d = ST_STATUS;
                    end else begin
                        widx_d = widx_q + 1'b1;
                    end
                end
            end
            ST_STATUS: if (tx_acc) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Inter-byte gap watchdog; holds its value outside the byte-receiving states.
        if (in_rx_state) begin
            if (rx_acc) begin
                gap_d = '0;
            end else if (gap_q == GW'(RX_GAP - 1)) begin
                gap_d   = '0;
                abort_d = 1'b1;
                state_d = ST_IDLE;
            end else begin
                gap_d = gap_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            len_q    <= '0;
            widx_q   <= '0;
            bcnt_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            status_q <= '0;
            gap_q    <= '0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            len_q    <= len_d;
            widx_q   <= widx_d;
            bcnt_q   <= bcnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            status_q <= status_d;
            gap_q    <= gap_d;
            abort_q  <= abort_d;
        end
    end

endmodule

// File: tb/tb_pgr_uart2apb_burst.sv
// Directed bench for pgr_uart2apb_burst: drives command frames, models an APB
// slave, and scoreboards response bytes and observed APB transfers.
module tb_pgr_uart2apb_burst;
  import pgr_uart2apb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_vld;
  logic        rx_rdy;
  logic [7:0]  tx_data;
  logic        tx_vld;
  logic        tx_rdy;
  logic        tx_rdy_man;
  logic        bp_en;
  logic        bp_bit;
  logic [3:0]  p_sel;
  logic [15:0] p_addr;
  logic [31:0] p_wdata;
  logic [3:0]  p_strb;
  logic        p_enable;
  logic        p_we;
  logic        p_ready;
  logic [31:0] p_rdata;
  logic        p_slverr;
  logic        busy;
  logic        frame_abort;
  state_t      dbg_state;

  // clock / reset block
  always #5 clk = ~clk;

  pgr_uart2apb_burst #(.AW(16), .DW(32), .NSEL(4), .TIMEOUT(8), .RX_GAP(100)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_rx_data(rx_data), .i_rx_vld(rx_vld), .o_rx_rdy(rx_rdy),
    .o_tx_data(tx_data), .o_tx_vld(tx_vld), .i_tx_rdy(tx_rdy),
    .o_p_sel(p_sel), .o_p_addr(p_addr), .o_p_wdata(p_wdata), .o_p_strb(p_strb),
    .o_p_enable(p_enable), .o_p_we(p_we),
    .i_p_ready(p_ready), .i_p_rdata(p_rdata), .i_p_slverr(p_slverr),
    .o_busy(busy), .o_frame_abort(frame_abort), .o_dbg_state(dbg_state)
  );

  // APB slave model
  logic ready_en;
  logic slverr_first;
  int   xfer_total = 0;
  int   k_base;
  assign p_ready  = p_enable & ready_en;
  assign p_rdata  = 32'h1111_1111 + 32'(xfer_total - k_base);
  assign p_slverr = slverr_first & (xfer_total == k_base);
  assign tx_rdy   = tx_rdy_man & (bp_en ? bp_bit : 1'b1);

  always @(posedge clk) if (p_enable && p_ready) xfer_total <= xfer_total + 1;

  always begin
    @(negedge clk);
    bp_bit = ($urandom_range(0, 2) != 0);
  end

  // monitor
  logic [7:0]  got_q[$];
  logic [15:0] txn_addr[$];
  logic [31:0] txn_wdata[$];
  logic [3:0]  txn_sel[$];
  logic [3:0]  txn_strb[$];
  logic        txn_we[$];
  int acc_cycles = 0, sel_cycles = 0, abort_cnt = 0, stab_err = 0, idle_err = 0;
  logic [15:0] su_addr;
  logic [31:0] su_wdata;
  logic [3:0]  su_sel;

  always begin
    @(negedge clk);
    #1;
    if (tx_vld && tx_rdy) got_q.push_back(tx_data);
    if (frame_abort) abort_cnt++;
    if (p_sel != 4'd0) sel_cycles++;
    if (p_enable) begin
      acc_cycles++;
      if (p_addr != su_addr || p_wdata != su_wdata || p_sel != su_sel) stab_err++;
    end else if (p_sel != 4'd0) begin
      su_addr = p_addr; su_wdata = p_wdata; su_sel = p_sel;
    end else if (p_addr != 16'd0 || p_wdata != 32'd0 || p_we || p_strb != 4'd0) begin
      idle_err++;
    end
    if (p_enable && p_ready) begin
      txn_addr.push_back(p_addr); txn_wdata.push_back(p_wdata);
      txn_sel.push_back(p_sel); txn_strb.push_back(p_strb); txn_we.push_back(p_we);
    end
  end

  // scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] frame_q[$];
  int checks = 0, failures = 0;
  int got_base, txn_base, acc_base, sel_base, abort_base;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start_test();
    exp_q.delete();
    got_base = got_q.size(); txn_base = txn_addr.size();
    acc_base = acc_cycles; sel_base = sel_cycles; abort_base = abort_cnt;
    k_base = xfer_total;
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data = b; rx_vld = 1'b1;
    while (!rx_rdy && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) check_eq("rx_rdy_wait", 64'(rx_rdy), 64'd1);
    @(negedge clk);
    rx_vld = 1'b0;
  endtask

  task automatic send_frame();
    foreach (frame_q[i]) send_byte(frame_q[i]);
  endtask

  task automatic check_tx(input string tag);
    int n = 0;
    while ((got_q.size() - got_base) < exp_q.size() && n < 3000) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    check_eq({tag, "_tx_len"}, 64'(got_q.size() - got_base), 64'(exp_q.size()));
    foreach (exp_q[i])
      if (got_base + i < got_q.size()) check_eq({tag, "_tx_byte"}, 64'(got_q[got_base + i]), 64'(exp_q[i]));
    check_eq({tag, "_busy_end"}, 64'(busy), 64'd0);
  endtask

  task automatic check_txn(input string tag, input int idx, input logic [15:0] a,
                           input logic [31:0] wd, input logic [3:0] sel, input logic we);
    if (txn_base + idx < txn_addr.size()) begin
      check_eq({tag, "_addr"}, 64'(txn_addr[txn_base + idx]), 64'(a));
      check_eq({tag, "_sel"},  64'(txn_sel[txn_base + idx]),  64'(sel));
      check_eq({tag, "_we"},   64'(txn_we[txn_base + idx]),   64'(we));
      check_eq({tag, "_strb"}, 64'(txn_strb[txn_base + idx]), 64'hF);
      if (we) check_eq({tag, "_wdata"}, 64'(txn_wdata[txn_base + idx]), 64'(wd));
    end else begin
      check_eq({tag, "_missing"}, 64'(txn_addr.size() - txn_base), 64'(idx + 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, herr;
    logic [31:0] w;
    rst = 1'b1; rx_vld = 1'b0; rx_data = 8'h00; tx_rdy_man = 1'b1; bp_en = 1'b0;
    ready_en = 1'b1; slverr_first = 1'b0; k_base = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_rx_rdy", 64'(rx_rdy), 64'd0);
    check_eq("rst_tx_vld", 64'(tx_vld), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_apb", 64'({p_sel, p_enable, p_we, p_strb}), 64'd0);
    check_eq("rst_abort", 64'(frame_abort), 64'd0);
    check_eq("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_rx_rdy", 64'(rx_rdy), 64'd1);

    // single write
    start_test();
    frame_q = '{8'h80, 8'h10, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    exp_q = '{8'h00};
    send_frame();
    check_tx("wr1");
    check_eq("wr1_ntxn", 64'(txn_addr.size() - txn_base), 64'd1);
    check_txn("wr1", 0, 16'h1004, 32'hDEAD_BEEF, 4'b0001, 1'b1);

    // read burst of 4 with random tx back-pressure
    start_test();
    bp_en = 1'b1;
    frame_q = '{8'h03, 8'h20, 8'h00};
    for (int k = 0; k < 4; k++) begin
      w = 32'h1111_1111 + 32'(k);
      for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
    end
    exp_q.push_back(8'h00);
    send_frame();
    check_tx("rd4");
    bp_en = 1'b0;
    check_eq("rd4_ntxn", 64'(txn_addr.size() - txn_base), 64'd4);
    for (int k = 0; k < 4; k++) check_txn("rd4", k, 16'h2000 + 16'(4 * k), 32'd0, 4'b0001, 1'b0);

    // timeout on first of two reads
    start_test();
    ready_en = 1'b0;
    frame_q = '{8'h01, 8'hC0, 8'h00};
    exp_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
    send_frame();
    check_tx("tmo");
    ready_en = 1'b1;
    check_eq("tmo_access_cycles", 64'(acc_cycles - acc_base), 64'd8);
    check_eq("tmo_sel_cycles", 64'(sel_cycles - sel_base), 64'd9);
    check_eq("tmo_ntxn", 64'(txn_addr.size() - txn_base), 64'd0);

    // slave error on first of two writes, address wraps
    start_test();
    slverr_first = 1'b1;
    frame_q = '{8'h81, 8'hFF, 8'hFC, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    exp_q = '{8'h01};
    send_frame();
    check_tx("slv");
    slverr_first = 1'b0;
    check_eq("slv_ntxn", 64'(txn_addr.size() - txn_base), 64'd1);
    check_eq("slv_access_cycles", 64'(acc_cycles - acc_base), 64'd1);
    check_txn("slv", 0, 16'hFFFC, 32'h1122_3344, 4'b1000, 1'b1);

    // inter-byte gap abort
    start_test();
    frame_q = '{8'h80, 8'h10};
    send_frame();
    n = 0;
    while (!frame_abort && n < 300) begin @(negedge clk); n++; end
    check_eq("gap_cycles", 64'(n), 64'd100);
    @(negedge clk);
    check_eq("gap_pulse_width", 64'(frame_abort), 64'd0);
    check_eq("gap_idle_rdy", 64'(rx_rdy), 64'd1);
    repeat (5) @(negedge clk);
    check_eq("gap_abort_cnt", 64'(abort_cnt - abort_base), 64'd1);
    check_eq("gap_no_tx", 64'(got_q.size() - got_base), 64'd0);
    start_test();
    frame_q = '{8'h80, 8'h30, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04};
    exp_q = '{8'h00};
    send_frame();
    check_tx("gap_next");
    check_txn("gap_next", 0, 16'h3008, 32'h0102_0304, 4'b0001, 1'b1);

    // bad command held under tx back-pressure
    start_test();
    tx_rdy_man = 1'b0;
    frame_q = '{8'h40};
    exp_q = '{8'h03};
    send_frame();
    herr = 0;
    for (int c = 0; c < 20; c++) begin
      if (!tx_vld || tx_data != 8'h03) herr++;
      @(negedge clk);
    end
    check_eq("bad_hold", 64'(herr), 64'd0);
    tx_rdy_man = 1'b1;
    check_tx("bad");
    check_eq("bad_ntxn", 64'(txn_addr.size() - txn_base), 64'd0);

    // reset mid-frame: no response, no pulse
    start_test();
    frame_q = '{8'h00, 8'h40};
    send_frame();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("mrst_rx_rdy", 64'(rx_rdy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("mrst_rx_rdy_after", 64'(rx_rdy), 64'd1);
    repeat (150) @(negedge clk);
    check_eq("mrst_no_abort", 64'(abort_cnt - abort_base), 64'd0);
    check_eq("mrst_no_tx", 64'(got_q.size() - got_base), 64'd0);
    start_test();
    frame_q = '{8'h00, 8'h40, 8'h00};
    exp_q = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h00};
    send_frame();
    check_tx("rd1");
    check_txn("rd1", 0, 16'h4000, 32'd0, 4'b0010, 1'b0);

    check_eq("apb_stable", 64'(stab_err), 64'd0);
    check_eq("apb_idle_zero", 64'(idle_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
